// File: rtl/cp_sto_estimator.sv
// cp_sto_estimator: streaming cyclic-prefix timing offset estimator.
// Tracks a sliding CP-length window of correlation (or difference) terms
// between x[k] and x[k-Nfft] and reports the window start with the best metric.
// Optional macro CP_STO_DIFF_MODE_EN compiles in the difference-min metric;
// without it the `mode` input is ignored and correlation-max is always used.
module cp_sto_estimator #(
  parameter int unsigned DW       = 12,
  parameter int unsigned CNT_W    = 12,
  parameter int unsigned MAX_NFFT = 256,
  parameter int unsigned MAX_NG   = 64,
  parameter int unsigned MW       = 2*DW+2+$clog2(MAX_NG)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  input  logic                 mode,
  input  logic [CNT_W-1:0]     Ng,
  input  logic [CNT_W-1:0]     Nfft,
  input  logic                 s_valid,
  input  logic signed [DW-1:0] s_i,
  input  logic signed [DW-1:0] s_q,
  output logic                 s_ready,
  output logic [CNT_W-1:0]     est_STO,
  output logic [MW-1:0]        metric_best,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned TW   = 2*DW+2;
  localparam int unsigned AW_D = $clog2(MAX_NFFT);
  localparam int unsigned AW_T = $clog2(MAX_NG);
  localparam int unsigned KW   = CNT_W+2;

  typedef enum logic [2:0] {IDLE, CHECK, SEARCH, DRAIN, DONE} state_t;

  state_t state, state_n;

  logic [CNT_W-1:0] ng_q, nfft_q;
  logic             cfg_ok, diff_sel, acc;
  logic [KW-1:0]    k, k1, k2, nfft_k, ng_k, win, win_m1, len_m1;
  logic [AW_D-1:0]  wp;
  logic [AW_T-1:0]  tp;
  logic [1:0]       drain_cnt;

  logic signed [DW-1:0] dl_i [MAX_NFFT];
  logic signed [DW-1:0] dl_q [MAX_NFFT];
  logic signed [TW-1:0] tl_re [MAX_NG];
  logic signed [TW-1:0] tl_im [MAX_NG];

  logic signed [DW-1:0] old_i, old_q;
  logic signed [TW-1:0] xr, xi, yr, yi, t_re, t_im;
  logic signed [TW-1:0] sub_re, sub_im;
  logic                 t1_v, s_v;
  logic signed [TW-1:0] t1_re, t1_im;
  logic signed [MW-1:0] s_re, s_im, a_re, a_im;
  logic [MW-1:0]        metric, best;
  logic [CNT_W-1:0]     best_d;
  logic                 better;

  assign cfg_ok = (ng_q >= CNT_W'(1)) && (ng_q <= CNT_W'(MAX_NG)) &&
                  (nfft_q >= CNT_W'(2)) && (nfft_q <= CNT_W'(MAX_NFFT)) &&
                  (ng_q <= nfft_q);

  assign nfft_k = KW'(nfft_q);
  assign ng_k   = KW'(ng_q);
  assign win    = nfft_k + ng_k;
  assign win_m1 = win - KW'(1);
  assign len_m1 = (win << 1) - KW'(2);
  assign acc    = s_valid & s_ready;

`ifdef CP_STO_DIFF_MODE_EN
  localparam int unsigned DW1 = DW+1;
  logic                 mode_q;
  logic signed [DW:0]   d_i, d_q;
  logic [DW:0]          dabs_i, dabs_q;

  // Run-time metric selection, latched with the rest of the configuration
  always_ff @(posedge clk) begin
    if (reset)                  mode_q <= 1'b0;
    else if (state == IDLE && go) mode_q <= mode;
  end

  assign diff_sel = mode_q;
  assign d_i      = DW1'(s_i) - DW1'(old_i);
  assign d_q      = DW1'(s_q) - DW1'(old_q);
  assign dabs_i   = d_i[DW] ? DW1'(-d_i) : DW1'(d_i);
  assign dabs_q   = d_q[DW] ? DW1'(-d_q) : DW1'(d_q);
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign diff_sel    = 1'b0;
`endif

  // Delayed sample x[k-Nfft] is the slot about to be overwritten
  assign old_i = dl_i[wp];
  assign old_q = dl_q[wp];
  assign xr    = TW'(s_i);
  assign xi    = TW'(s_q);
  assign yr    = TW'(old_i);
  assign yi    = TW'(old_q);

  // Term t[k]; zero until the delay line holds a full FFT length
  always_comb begin
    t_re = '0;
    t_im = '0;
    if (k >= nfft_k) begin
      if (diff_sel) begin
`ifdef CP_STO_DIFF_MODE_EN
        t_re = TW'(dabs_i) + TW'(dabs_q);
`endif
      end else begin
        t_re = xr*yr + xi*yi;
        t_im = xi*yr - xr*yi;
      end
    end
  end

  // Term leaving the window; only real once Ng terms past Nfft exist
  assign sub_re = (k1 >= win) ? tl_re[tp] : '0;
  assign sub_im = (k1 >= win) ? tl_im[tp] : '0;

  assign a_re = s_re[MW-1] ? -s_re : s_re;
  assign a_im = s_im[MW-1] ? -s_im : s_im;

`ifdef CP_STO_DIFF_MODE_EN
  assign metric = diff_sel ? $unsigned(s_re) : ($unsigned(a_re) + $unsigned(a_im));
  assign better = diff_sel ? (metric < best) : (metric > best);
`else
  assign metric = $unsigned(a_re) + $unsigned(a_im);
  assign better = metric > best;
`endif

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (go) state_n = CHECK;
      CHECK:   state_n = cfg_ok ? SEARCH : DONE;
      SEARCH:  if (acc && (k == len_m1)) state_n = DRAIN;
      DRAIN:   if (drain_cnt == 2'd2) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      s_ready     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      est_STO     <= '0;
      metric_best <= '0;
    end else begin
      state   <= state_n;
      s_ready <= (state_n == SEARCH);
      busy    <= (state_n != IDLE);
      done    <= (state_n == DONE);
      err     <= (state_n == DONE) && !cfg_ok;
      if (state_n == DONE) begin
        est_STO     <= cfg_ok ? best_d : '0;
        metric_best <= cfg_ok ? best : '0;
      end
    end
  end

  // Configuration, counters and the term/sum/compare pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      ng_q      <= '0;
      nfft_q    <= '0;
      drain_cnt <= '0;
      k         <= '0;
      k1        <= '0;
      k2        <= '0;
      wp        <= '0;
      tp        <= '0;
      t1_v      <= 1'b0;
      s_v       <= 1'b0;
      t1_re     <= '0;
      t1_im     <= '0;
      s_re      <= '0;
      s_im      <= '0;
      best      <= '0;
      best_d    <= '0;
    end else begin
      if (state == IDLE && go) begin
        ng_q   <= Ng;
        nfft_q <= Nfft;
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      if (state == CHECK) begin
        k      <= '0;
        wp     <= '0;
        tp     <= '0;
        t1_v   <= 1'b0;
        s_v    <= 1'b0;
        s_re   <= '0;
        s_im   <= '0;
        best   <= diff_sel ? '1 : '0;
        best_d <= '0;
      end else begin
        t1_v <= acc;
        if (acc) begin
          t1_re <= t_re;
          t1_im <= t_im;
          k1    <= k;
          k     <= k + KW'(1);
          wp    <= (KW'(wp) == nfft_k - KW'(1)) ? '0 : wp + AW_D'(1);
        end
        s_v <= t1_v;
        if (t1_v) begin
          s_re <= s_re + MW'(t1_re) - MW'(sub_re);
          s_im <= s_im + MW'(t1_im) - MW'(sub_im);
          k2   <= k1;
          tp   <= (KW'(tp) == ng_k - KW'(1)) ? '0 : tp + AW_T'(1);
        end
        if (s_v && (k2 >= win_m1) && better) begin
          best   <= metric;
          best_d <= CNT_W'(k2 - win_m1);
        end
      end
    end
  end

  // Sample delay line and term line; stale slots are masked by index gating
  always_ff @(posedge clk) begin
    if (acc) begin
      dl_i[wp] <= s_i;
      dl_q[wp] <= s_q;
    end
    if (t1_v) begin
      tl_re[tp] <= t1_re;
      tl_im[tp] <= t1_im;
    end
  end

endmodule
